// File: rtl/video_scanout.sv
// rtl/video_scanout.sv - raster sync/blank timing and framebuffer scanout with in-order prefetch FIFO
// Fetch side runs every clock; raster and pixel side advance only on ce.
module video_scanout #(
  parameter int H_VISIBLE   = 512,
  parameter int H_TOTAL     = 704,
  parameter int HSYNC_START = 540,
  parameter int HSYNC_END   = 607,
  parameter int V_START     = 21,
  parameter int V_END       = 362,
  parameter int V_TOTAL     = 370,
  parameter int VSYNC_START = 365,
  parameter int VSYNC_END   = 369,
  parameter int BPP         = 1,
  parameter int ADDR_W      = 15,
  parameter logic [ADDR_W-1:0] BASE0 = 15'h5380,
  parameter logic [ADDR_W-1:0] BASE1 = 15'h1380,
  parameter int FIFO_DEPTH  = 4,
  parameter int INVERT      = 1
) (
  input  logic              clk,
  input  logic              _reset,
  input  logic              ce,
  input  logic              page_sel,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic              rd_valid,
  input  logic [15:0]       rd_data,
  output logic              hsync,
  output logic              vsync,
  output logic              _hblank,
  output logic              _vblank,
  output logic              video_en,
  output logic [BPP-1:0]    pixel,
  output logic              underflow,
  input  logic              underflow_clr
);

  localparam int PPW     = 16 / BPP;
  localparam int SW      = $clog2(PPW);
  localparam int N_WORDS = (V_END - V_START + 1) * (H_VISIBLE / PPW);
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_TOTAL);
  localparam int IW      = $clog2(N_WORDS + 1);
  localparam int PW      = $clog2(FIFO_DEPTH);
  localparam int CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [BPP-1:0] INV_MASK = (INVERT != 0) ? {BPP{1'b1}} : {BPP{1'b0}};

  logic [XW-1:0]   xpos;
  logic [YW-1:0]   ypos;
  logic [15:0]     fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   fcount, outstanding, out_next;
  logic [IW-1:0]   index, drop_cnt;
  logic            page, fetch_on, blank_word;
  logic [15:0]     shreg, head;
  logic            visible, frame_start, pop_slot, fifo_empty, do_pop, uf_set;
  logic            drop_now, do_push, xfer, credit_ok, done;

  assign visible     = (xpos < XW'(H_VISIBLE)) && (ypos >= YW'(V_START)) && (ypos <= YW'(V_END));
  assign frame_start = ce && (xpos == '0) && (ypos == '0);
  assign pop_slot    = ce && visible && (xpos[SW-1:0] == '0);
  assign fifo_empty  = (fcount == '0);
  assign do_pop      = pop_slot && !fifo_empty;
  assign uf_set      = pop_slot && fifo_empty;
  assign drop_now    = rd_valid && (drop_cnt != '0);
  assign do_push     = rd_valid && !drop_now;
  assign head        = fifo_mem[rd_ptr];

  // Credits count returns still in flight, so the FIFO cannot overflow.
  assign credit_ok = ((CW+1)'(fcount) + (CW+1)'(outstanding)) < (CW+1)'(FIFO_DEPTH);
  assign done      = (index == IW'(N_WORDS));
  assign rd_req    = fetch_on && !done && credit_ok;
  assign rd_addr   = (page ? BASE1 : BASE0) + ADDR_W'(index);
  assign xfer      = rd_req && rd_ack;
  assign out_next  = outstanding + CW'(xfer) - CW'(rd_valid);

  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr] <= rd_data;
  end

  // drop_cnt: returns to discard, either stale at frame start or words already skipped by underflow.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      fetch_on    <= 1'b0;
      page        <= 1'b0;
      index       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      fcount      <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (frame_start) begin
      fetch_on    <= 1'b1;
      page        <= page_sel;
      index       <= '0;
      outstanding <= out_next;
      drop_cnt    <= IW'(out_next);
      fcount      <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      if (xfer) index <= index + 1'b1;
      outstanding <= out_next;
      drop_cnt    <= drop_cnt - IW'(drop_now) + IW'(uf_set);
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      fcount <= fcount + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      xpos       <= '0;
      ypos       <= '0;
      hsync      <= 1'b0;
      vsync      <= 1'b0;
      _hblank    <= 1'b1;
      _vblank    <= 1'b0;
      video_en   <= 1'b0;
      pixel      <= '0;
      shreg      <= '0;
      blank_word <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (uf_set)             underflow <= 1'b1;
      else if (underflow_clr) underflow <= 1'b0;
      if (ce) begin
        if (xpos == XW'(H_TOTAL - 1)) begin
          xpos <= '0;
          ypos <= (ypos == YW'(V_TOTAL - 1)) ? '0 : ypos + 1'b1;
        end else begin
          xpos <= xpos + 1'b1;
        end
        hsync    <= (xpos >= XW'(HSYNC_START)) && (xpos <= XW'(HSYNC_END));
        vsync    <= (ypos >= YW'(VSYNC_START)) && (ypos <= YW'(VSYNC_END));
        _hblank  <= (xpos < XW'(H_VISIBLE));
        _vblank  <= (ypos >= YW'(V_START)) && (ypos <= YW'(V_END));
        video_en <= visible;
        if (pop_slot) begin
          // A missing word is shown as pixel 0 rather than as inverted zeros.
          blank_word <= fifo_empty;
          shreg      <= fifo_empty ? 16'h0000 : (head << BPP);
          pixel      <= fifo_empty ? '0 : (head[15 -: BPP] ^ INV_MASK);
        end else if (visible) begin
          shreg <= shreg << BPP;
          pixel <= blank_word ? '0 : (shreg[15 -: BPP] ^ INV_MASK);
        end else begin
          pixel <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_video_scanout.sv
// tb/tb_video_scanout.sv - bench for video_scanout on a reduced raster (48x8, 32x4 visible)
module tb_video_scanout;
  localparam int FRAME = 48 * 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0, ce = 1'b0, page_sel = 1'b0, uf_clr = 1'b0, ack_en = 1'b1;
  logic rd_req1, rd_valid1 = 1'b0;
  logic [14:0] rd_addr1;
  logic [15:0] rd_data1 = 16'h0;
  logic hs1, vs1, hb1, vb1, ven1, uf1;
  logic [0:0] pix1;
  logic rd_req2, rd_valid2 = 1'b0, hs2, vs2, hb2, vb2, ven2, uf2;
  logic [14:0] rd_addr2;
  logic [15:0] rd_data2 = 16'h0;
  logic [1:0] pix2;

  video_scanout #(.H_VISIBLE(32), .H_TOTAL(48), .HSYNC_START(36), .HSYNC_END(39),
    .V_START(2), .V_END(5), .V_TOTAL(8), .VSYNC_START(6), .VSYNC_END(7), .BPP(1), .FIFO_DEPTH(4))
  u1 (.clk(clk), ._reset(rst_n), .ce(ce), .page_sel(page_sel), .rd_req(rd_req1), .rd_addr(rd_addr1),
      .rd_ack(ack_en), .rd_valid(rd_valid1), .rd_data(rd_data1), .hsync(hs1), .vsync(vs1),
      ._hblank(hb1), ._vblank(vb1), .video_en(ven1), .pixel(pix1), .underflow(uf1),
      .underflow_clr(uf_clr));

  video_scanout #(.H_VISIBLE(32), .H_TOTAL(48), .HSYNC_START(36), .HSYNC_END(39),
    .V_START(2), .V_END(5), .V_TOTAL(8), .VSYNC_START(6), .VSYNC_END(7), .BPP(2), .FIFO_DEPTH(4))
  u2 (.clk(clk), ._reset(rst_n), .ce(ce), .page_sel(1'b0), .rd_req(rd_req2), .rd_addr(rd_addr2),
      .rd_ack(1'b1), .rd_valid(rd_valid2), .rd_data(rd_data2), .hsync(hs2), .vsync(vs2),
      ._hblank(hb2), ._vblank(vb2), .video_en(ven2), .pixel(pix2), .underflow(uf2),
      .underflow_clr(1'b0));

  int total = 0, bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [14:0] a, input logic [15:0] first);
    return (a == 15'h5380) ? first : {a[7:0], ~a[7:0]};
  endfunction

  // Memory for u1: fixed latency (lat clocks) after each accepted request, in order.
  typedef struct { int due; logic [15:0] d; } ret_t;
  ret_t mq[$];
  logic [15:0] sbq[$];
  int cyc = 0, lat = 1, xcnt = 0, nce = 0;
  logic [14:0] first_addr = '0, last_addr = '0;
  logic sb_on = 1'b1;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    rd_valid1 = 1'b0;
    if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
      rd_valid1 = 1'b1;
      rd_data1  = mq[0].d;
      if (sb_on) sbq.push_back(~mq[0].d);
      void'(mq.pop_front());
    end
    if (rd_req1 && ack_en) begin
      mq.push_back('{cyc + 1 + lat, mem_word(rd_addr1, 16'h8000)});
      if (xcnt == 0) first_addr = rd_addr1;
      last_addr = rd_addr1;
      xcnt++;
    end
  end

  logic p2 = 1'b0;
  logic [14:0] pa2 = '0;
  always @(negedge clk) begin
    rd_valid2 = p2 && rst_n;
    rd_data2  = mem_word(pa2, 16'h1B00);
    p2  = rd_req2 && rst_n;
    pa2 = rd_addr2;
  end

  // Scoreboard: every 16 visible pixels of u1 must equal the next returned word, inverted.
  logic prev_ce = 1'b0;
  logic [15:0] acc = '0;
  int nacc = 0;
  always @(negedge clk) begin
    if (prev_ce && sb_on && ven1) begin
      acc = {acc[14:0], pix1};
      nacc++;
      if (nacc == 16) begin
        nacc = 0;
        if (sbq.size() == 0) chk("sb_empty", 1, 0);
        else chk("sb_word", acc, sbq.pop_front());
      end
    end
    prev_ce = ce;
  end

  task automatic ce_step();
    ce = 1'b1;
    @(posedge clk); #1;
    ce = 1'b0;
    if ((nce + 1) % FRAME == 1) xcnt = 0;
    @(posedge clk); #1;
    nce++;
  endtask

  task automatic goto(input int p);
    while (nce < p + 1) ce_step();
  endtask

  typedef struct { int pos; logic [7:0] exp; } vec_t;
  vec_t tab[$];
  function automatic void add(input int p, input logic [7:0] e);
    tab.push_back('{p, e});
  endfunction

  // Expected bits: {hsync, vsync, _hblank, _vblank, video_en, pixel(bpp1), pixel(bpp2)[1:0]}
  initial begin
    add(0,   8'b0010_0000); add(31,  8'b0010_0000); add(32,  8'b0000_0000);
    add(35,  8'b0000_0000); add(36,  8'b1000_0000); add(39,  8'b1000_0000);
    add(40,  8'b0000_0000); add(95,  8'b0000_0000); add(96,  8'b0011_1011);
    add(97,  8'b0011_1110); add(98,  8'b0011_1101); add(99,  8'b0011_1100);
    add(100, 8'b0011_1111); add(111, 8'b0011_1101); add(112, 8'b0011_1001);
    add(113, 8'b0011_1111); add(127, 8'b0011_1111); add(128, 8'b0001_0000);
    add(271, 8'b0011_1111); add(288, 8'b0110_0000); add(373, 8'b1100_0000);
    add(383, 8'b0100_0000);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {rd_req1, hs1, vs1, hb1, vb1, ven1, pix1, uf1}, 8'b0001_0000);
    chk("reset_addr", rd_addr1, 15'h5380);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_before_frame", rd_req1, 0);

    for (int i = 0; i < tab.size(); i++) begin
      goto(tab[i].pos);
      chk($sformatf("timing_pos%0d", tab[i].pos), {hs1, vs1, hb1, vb1, ven1, pix1, pix2}, tab[i].exp);
    end
    chk("f1_count", xcnt, 8);
    chk("f1_first", first_addr, 15'h5380);
    chk("f1_last", last_addr, 15'h5387);
    chk("f1_idle", rd_req1, 0);

    lat = 3;
    goto(FRAME);
    chk("wrap_pos0", {hs1, vs1, hb1, vb1, ven1}, 5'b00100);
    goto(FRAME + 50);
    page_sel = 1'b1;
    goto(2 * FRAME - 1);
    chk("f2_count", xcnt, 8);
    chk("f2_last_page0", last_addr, 15'h5387);
    goto(2 * FRAME + 5);
    chk("f3_first_page1", first_addr, 15'h1380);
    page_sel = 1'b0;
    goto(3 * FRAME - 1);
    chk("f3_last_page1", last_addr, 15'h1387);

    sb_on = 1'b0;
    ack_en = 1'b0;
    goto(3 * FRAME + 96);
    chk("uf_first_word", {uf1, ven1, pix1}, 3'b110);
    goto(3 * FRAME + 97);
    chk("uf_pixel_zero", pix1, 0);
    goto(3 * FRAME + 106);
    uf_clr = 1'b1;
    @(posedge clk); #1;
    uf_clr = 1'b0;
    chk("uf_clear", uf1, 0);
    goto(3 * FRAME + 111);
    uf_clr = 1'b1;
    ce = 1'b1;
    @(posedge clk); #1;
    ce = 1'b0;
    uf_clr = 1'b0;
    @(posedge clk); #1;
    nce++;
    chk("uf_set_wins", uf1, 1);
    goto(3 * FRAME + 136);
    ack_en = 1'b1;
    goto(3 * FRAME + 144);
    chk("realign_x0", pix1, 0);
    goto(3 * FRAME + 145);
    chk("realign_x1", pix1, 1);
    goto(3 * FRAME + 150);
    chk("realign_x6", pix1, 0);
    uf_clr = 1'b1;
    @(posedge clk); #1;
    uf_clr = 1'b0;
    goto(4 * FRAME - 1);
    chk("uf_quiet", uf1, 0);

    lat = 40;
    goto(4 * FRAME + 114);
    chk("outstanding_two", mq.size(), 2);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", {rd_req1, hs1, vs1, hb1, vb1, ven1, pix1, uf1}, 8'b0001_0000);
    chk("rst_mid_addr", rd_addr1, 15'h5380);
    mq.delete();
    sbq.delete();
    nacc = 0;
    lat = 2;
    @(posedge clk); #1;
    rst_n = 1'b1;
    nce = 0;
    sb_on = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", rd_req1, 0);
    ce_step();
    chk("post_rst_req_seen", xcnt > 0, 1);
    chk("post_rst_first", first_addr, 15'h5380);
    goto(FRAME - 1);
    chk("post_rst_count", xcnt, 8);
    chk("post_rst_uf", uf1, 0);
    chk("sb_drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
